// File: rtl/scope_capture_ctrl.sv
// Oscilloscope capture sequencer: circular pre-trigger buffer, level trigger,
// post-trigger fill and chronological readout through an async-read RAM.
module scope_capture_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pretrig,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_falling,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr_in,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  rd_start,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE,
    READ
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH-1:0] cfg_pretrig;
  logic [DATA_WIDTH-1:0] cfg_level;
  logic                  cfg_falling;
  logic [DATA_WIDTH-1:0] prev_sample;
  logic                  prev_valid;

  logic wr_state;
  logic edge_rise;
  logic edge_fall;
  logic trig_hit;
  logic pre_full;
  logic post_end;
  logic last_beat;
  logic no_post;

  assign wr_state  = (state == PRE) || (state == WAIT_TRIG) ||
                     (state == POST);
  assign edge_rise = prev_valid && (prev_sample < cfg_level) &&
                     (sample_in >= cfg_level);
  assign edge_fall = prev_valid && (prev_sample >= cfg_level) &&
                     (sample_in < cfg_level);
  assign trig_hit  = sample_valid &&
                     (force_trig || (cfg_falling ? edge_fall : edge_rise));
  assign pre_full  = sample_valid && ((fill_cnt + ONE) == cfg_pretrig);
  assign post_end  = sample_valid && (post_cnt == ONE);
  assign last_beat = (rd_cnt == LAST);
  // DEPTH-1-pretrig is just the bitwise complement of pretrig
  assign no_post   = (~cfg_pretrig == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) state_nx = (pretrig == '0) ? WAIT_TRIG : PRE;
        end
        PRE: begin
          if (pre_full) state_nx = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig_hit) state_nx = no_post ? DONE : POST;
        end
        POST: begin
          if (post_end) state_nx = DONE;
        end
        DONE: begin
          if (rd_start) state_nx = READ;
        end
        READ: begin
          if (rd_ready && last_beat) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      rd_cnt      <= '0;
      trig_addr   <= '0;
      cfg_pretrig <= '0;
      cfg_level   <= '0;
      cfg_falling <= 1'b0;
      prev_sample <= '0;
      prev_valid  <= 1'b0;
      triggered   <= 1'b0;
    end else if (abort) begin
      triggered <= 1'b0;
    end else begin
      if (state == IDLE && arm) begin
        cfg_pretrig <= pretrig;
        cfg_level   <= trig_level;
        cfg_falling <= trig_falling;
        wr_ptr      <= '0;
        fill_cnt    <= '0;
        prev_valid  <= 1'b0;
        triggered   <= 1'b0;
      end
      if (wr_state && sample_valid) begin
        wr_ptr      <= wr_ptr + ONE;
        prev_sample <= sample_in;
        prev_valid  <= 1'b1;
      end
      if (state == PRE && sample_valid) begin
        fill_cnt <= fill_cnt + ONE;
      end
      if (state == WAIT_TRIG && trig_hit) begin
        trig_addr <= wr_ptr;
        triggered <= 1'b1;
        post_cnt  <= ~cfg_pretrig;
      end
      if (state == POST && sample_valid) begin
        post_cnt <= post_cnt - ONE;
      end
      if (state == DONE && rd_start) begin
        rd_ptr <= trig_addr - cfg_pretrig;
        rd_cnt <= '0;
      end
      if (state == READ && rd_ready) begin
        rd_ptr <= rd_ptr + ONE;
        rd_cnt <= rd_cnt + ONE;
        if (last_beat) triggered <= 1'b0;
      end
    end
  end

  always_comb begin
    ram_cs       = 1'b0;
    ram_we       = 1'b0;
    ram_oe       = 1'b0;
    ram_addr_in  = '0;
    ram_data_in  = '0;
    ram_addr_out = '0;
    rd_data      = '0;
    rd_valid     = 1'b0;
    rd_last      = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    if (wr_state) begin
      ram_cs      = 1'b1;
      // an abort or reset this cycle must not land one more write
      ram_we      = sample_valid && !abort && rst_n;
      ram_addr_in = wr_ptr;
      ram_data_in = sample_in;
    end
    if (state == DONE) begin
      done = 1'b1;
    end
    if (state == READ) begin
      ram_cs       = 1'b1;
      ram_oe       = 1'b1;
      ram_addr_out = rd_ptr;
      rd_data      = ram_rd_data;
      rd_valid     = 1'b1;
      rd_last      = last_beat;
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: scenario table plus
// hand sequences for reset and abort, with a behavioural sample RAM.
module tb_scope_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic       abort;
  logic [7:0] pretrig;
  logic [7:0] trig_level;
  logic       trig_falling;
  logic       force_trig;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       ram_cs;
  logic       ram_we;
  logic       ram_oe;
  logic [7:0] ram_addr_in;
  logic [7:0] ram_data_in;
  logic [7:0] ram_addr_out;
  logic [7:0] ram_rd_data;
  logic       rd_start;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       rd_last;
  logic       busy;
  logic       triggered;
  logic       done;

  always #5 clk = ~clk;

  scope_capture_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .pretrig(pretrig), .trig_level(trig_level),
    .trig_falling(trig_falling), .force_trig(force_trig),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr_in(ram_addr_in), .ram_data_in(ram_data_in),
    .ram_addr_out(ram_addr_out), .ram_rd_data(ram_rd_data),
    .rd_start(rd_start), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy),
    .triggered(triggered), .done(done)
  );

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr_in] <= ram_data_in;
  end
  assign ram_rd_data = mem[ram_addr_out];

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int pre;
    int lvl;
    bit fall;
    bit desc;
    int force_k;
    int glitch_k;
    bit bp;
    int trig_k;
    int trig_addr;
    int first_val;
  } scen_t;

  scen_t tbl[5];
  bit [7:0] hist[$];

  function automatic bit [7:0] val(input bit desc, input int k);
    return desc ? 8'(255 - k) : 8'(k);
  endfunction

  task automatic run_capture(input scen_t s, input string tag);
    int k, cyc, tk, post, b, start, base;
    bit v;
    hist.delete();
    pretrig = 8'(s.pre);
    trig_level = 8'(s.lvl);
    trig_falling = s.fall;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk({tag, "/busy_after_arm"}, busy, 1);
    k = 0;
    cyc = 0;
    tk = -1;
    post = 0;
    while (!done && cyc < 3000) begin
      v = (cyc % 7) != 3;
      sample_valid = v;
      sample_in = val(s.desc, k);
      force_trig = (k == s.force_k);
      if (v && k == s.glitch_k) begin
        arm = 1'b1;
        pretrig = 8'd3;
      end
      step();
      arm = 1'b0;
      pretrig = 8'(s.pre);
      if (v) begin
        hist.push_back(val(s.desc, k));
        if (tk < 0) begin
          if (triggered) tk = k;
        end else begin
          post++;
        end
        k++;
      end
      cyc++;
    end
    sample_valid = 1'b0;
    force_trig = 1'b0;
    chk({tag, "/done"}, done, 1);
    chk({tag, "/trig_sample"}, tk, s.trig_k);
    chk({tag, "/post_samples"}, post, 255 - s.pre);
    chk({tag, "/triggered"}, triggered, 1);
    chk({tag, "/we_in_done"}, ram_we, 0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    start = (s.trig_addr - s.pre) & 255;
    base = hist.size() - 256;
    b = 0;
    cyc = 0;
    while (b < 256 && cyc < 2000) begin
      rd_ready = s.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      chk({tag, "/rd_valid"}, rd_valid, 1);
      chk({tag, "/rd_addr"}, ram_addr_out, (start + b) & 255);
      if (base >= 0) chk({tag, "/rd_data"}, rd_data, hist[base + b]);
      chk({tag, "/rd_last"}, rd_last, (b == 255) ? 1 : 0);
      if (b == 0) chk({tag, "/first_val"}, rd_data, s.first_val);
      step();
      if (rd_ready) b++;
      cyc++;
    end
    rd_ready = 1'b0;
    chk({tag, "/beats"}, b, 256);
    chk({tag, "/busy_end"}, busy, 0);
    chk({tag, "/trig_cleared"}, triggered, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cyc;
    int after;
    tbl[0] = '{pre: 16, lvl: 128, fall: 0, desc: 0, force_k: -1,
               glitch_k: -1, bp: 0, trig_k: 128, trig_addr: 128,
               first_val: 112};
    tbl[1] = '{pre: 10, lvl: 251, fall: 1, desc: 1, force_k: -1,
               glitch_k: -1, bp: 1, trig_k: 261, trig_addr: 5,
               first_val: 4};
    tbl[2] = '{pre: 0, lvl: 0, fall: 0, desc: 0, force_k: 0,
               glitch_k: -1, bp: 0, trig_k: 0, trig_addr: 0,
               first_val: 0};
    tbl[3] = '{pre: 255, lvl: 200, fall: 0, desc: 0, force_k: 255,
               glitch_k: -1, bp: 0, trig_k: 255, trig_addr: 255,
               first_val: 0};
    tbl[4] = '{pre: 16, lvl: 128, fall: 0, desc: 0, force_k: -1,
               glitch_k: 50, bp: 1, trig_k: 128, trig_addr: 128,
               first_val: 112};

    rst_n = 1'b0;
    arm = 1'b1;
    abort = 1'b0;
    pretrig = 8'd4;
    trig_level = 8'd0;
    trig_falling = 1'b0;
    force_trig = 1'b0;
    sample_in = 8'h55;
    sample_valid = 1'b1;
    rd_start = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst/busy", busy, 0);
      chk("rst/ram_we", ram_we, 0);
      chk("rst/ram_cs", ram_cs, 0);
      chk("rst/ram_oe", ram_oe, 0);
      chk("rst/done", done, 0);
      chk("rst/rd_valid", rd_valid, 0);
      chk("rst/rd_last", rd_last, 0);
      chk("rst/triggered", triggered, 0);
      chk("rst/addr_out", ram_addr_out, 0);
    end
    arm = 1'b0;
    sample_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle/busy", busy, 0);
    chk("idle/ram_cs", ram_cs, 0);

    for (int i = 0; i < 5; i++) begin
      run_capture(tbl[i], $sformatf("scen%0d", i));
    end

    pretrig = 8'd16;
    trig_level = 8'd128;
    trig_falling = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    k = 0;
    cyc = 0;
    after = -1;
    while (after < 10 && cyc < 600) begin
      sample_valid = 1'b1;
      sample_in = 8'(k);
      step();
      k++;
      if (after >= 0) after++;
      else if (triggered) after = 0;
      cyc++;
    end
    chk("abort/in_post", after, 10);
    sample_in = 8'(k);
    abort = 1'b1;
    #1;
    chk("abort/we_same_cycle", ram_we, 0);
    step();
    abort = 1'b0;
    chk("abort/busy", busy, 0);
    chk("abort/ram_we", ram_we, 0);
    chk("abort/done", done, 0);
    step();
    chk("abort/idle_hold", busy, 0);
    sample_valid = 1'b0;
    run_capture(tbl[0], "rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
